sent_crc_sched: RTL and testbench
=================================

# sent_crc_sched

Two-requester scheduler for the shared SENT CRC4 engine. It arbitrates between requesters (for example the fast-channel transmitter and the receive checker), latches the granted requester's data nibbles, and steps them one per clock through the CRC4 core. It optionally applies the recommended zero-nibble augmentation, then returns the 4-bit checksum with a one-cycle valid pulse tagged with the owner.

## Interface
Parameters:
- MAX_NIBBLES, 6: maximum data nibbles per frame; range 1..6.
- LEN_W, 3: width of the length inputs.

Ports (clock and reset first):
- clk  in  1  clock.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- req  in  2  per-requester request, level; held high until that requester's crc_valid.
- data0  in  4*MAX_NIBBLES  requester 0 nibbles; nibble k at [4k+3:4k]; nibble 0 is processed first.
- len0  in  LEN_W  requester 0 data nibble count.
- data1  in  4*MAX_NIBBLES  requester 1 nibbles, same layout as data0.
- len1  in  LEN_W  requester 1 data nibble count.
- gnt  out  2  one-hot grant; high from the first CRC cycle through DONE inclusive.
- busy  out  1  high whenever the state is not IDLE.
- crc  out  4  checksum; holds its value until the next DONE.
- crc_valid  out  1  single-cycle pulse in DONE.
- crc_id  out  1  owner of crc; updated at DONE.

## Operation
- Algorithm: seed 4'h5; polynomial x^4+x^3+x^2+1; per nibble, crc_next = TABLE[crc] ^ nibble.
  - TABLE[i] is the XOR of the contributions of i's set bits: bit0 gives 0xD, bit1 gives 0x7, bit2 gives 0xE, bit3 gives 0x1.
  - Only data nibbles are processed. The status nibble is excluded.
- States:
  - IDLE: on any unmasked req, grant it, capture its data into the shift register, capture its length (clamped to MAX_NIBBLES), and seed crc. Go to CRC, or go straight to AUG/DONE if the length is 0.
  - CRC: feed one nibble per cycle and shift the register right by 4. Decrement the count. After the last nibble go to AUG when recommended mode is active, otherwise to DONE.
  - AUG: feed nibble 4'h0 once, then go to DONE.
  - DONE: assert crc_valid, drive crc_id, then go to IDLE.
- Arbitration:
  - Round-robin. The priority pointer resets to requester 0.
  - After a requester completes, the other requester has priority.
  - In the IDLE cycle right after DONE, the just-served requester's req is masked, giving it one cycle to drop req.
- Data and length are sampled only at grant. Later changes are ignored.
- If a requester drops req mid-operation, the frame still completes and crc_valid still pulses.
- len = 0: zero data nibbles. Result is 0x5 in legacy mode and 0x3 in recommended mode.
- len > MAX_NIBBLES: clamped to MAX_NIBBLES.

## Timing
- Reset values: all outputs are 0, state is IDLE, pointer is 0, crc register is 0.
- Grant timing: req is sampled high in IDLE at cycle T. gnt and busy are high from T+1. CRC occupies T+1..T+len.
- Recommended mode: AUG at T+len+1, crc_valid at T+len+2.
- Legacy mode: crc_valid at T+len+1.
- The next grant is possible no earlier than 2 cycles after crc_valid.
- Reset asserted mid-frame: immediate return to IDLE, all outputs 0, no crc_valid.
- Both req high in IDLE: the pointer decides; the loser waits and keeps req high.

## Configuration
- SENT_CRC_LEGACY_EN defined: no AUG state; the checksum covers the data nibbles only (legacy SENT).
- SENT_CRC_LEGACY_EN undefined: the zero-nibble augmentation step is applied (recommended SENT).

## Structure
- sent_pkg holds:
  - CRC_SEED = 4'h5
  - CRC_TABLE contribution constants
  - the nibble typedef
  - the state enum {IDLE, CRC, AUG, DONE}
- Sub-module sent_crc4_core holds the 4-bit register:
  - ports: clk, reset_n, init, enable, din[3:0], dout[3:0]
  - init loads the seed; enable applies one table step.
- The scheduler owns the FSM, the arbiter, the shift register and the counter.

## Test plan
- Requester 0, len0 = 6, all-zero data, recommended mode: crc = 0x5, crc_id = 0, crc_valid exactly at T+8.
- Same stimulus with SENT_CRC_LEGACY_EN: crc = 0xF, crc_valid at T+7.
- Both req rise in the same cycle after reset: requester 0 is served first, then requester 1 with no gap beyond 1 idle cycle. crc_id goes 0 then 1.
- len1 = 0, recommended mode: crc = 0x3, crc_valid at T+2. With legacy: crc = 0x5 at T+1.
- reset_n pulsed low during CRC: gnt, busy, crc and crc_valid go to 0 at once. A fresh request afterwards completes normally.
- data0 changed and req0 dropped after grant: crc matches the data sampled at grant, and crc_valid still pulses.

Source files
------------

// File: rtl/sent_pkg.sv
// Shared types and constants for the SENT CRC4 scheduler slice.
// Holds the CRC seed, table contributions, nibble type, FSM states and step helper.
package sent_pkg;

    typedef logic [3:0] nibble_t;

    localparam nibble_t CRC_SEED = 4'h5;

    // Contribution of each set bit of the current CRC to the table entry
    localparam nibble_t CRC_C0 = 4'hD;
    localparam nibble_t CRC_C1 = 4'h7;
    localparam nibble_t CRC_C2 = 4'hE;
    localparam nibble_t CRC_C3 = 4'h1;

    typedef enum logic [1:0] {
        IDLE,
        CRC,
        AUG,
        DONE
    } state_t;

    // One CRC4 step: TABLE[c] ^ d, TABLE built from per-bit contributions
    function automatic nibble_t crc_step(nibble_t c, nibble_t d);
        nibble_t t;
        t = d;
        if (c[0]) t = t ^ CRC_C0;
        if (c[1]) t = t ^ CRC_C1;
        if (c[2]) t = t ^ CRC_C2;
        if (c[3]) t = t ^ CRC_C3;
        return t;
    endfunction

endpackage

// File: rtl/sent_crc4_core.sv
// SENT CRC4 register: init loads the seed, enable applies one table step.
// Ports: clk, reset_n (async low), init, enable, din[3:0], dout[3:0].
import sent_pkg::*;

module sent_crc4_core (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    init,
    input  logic    enable,
    input  nibble_t din,
    output nibble_t dout
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= 4'h0;
        end else if (init) begin
            dout <= CRC_SEED;
        end else if (enable) begin
            dout <= crc_step(dout, din);
        end
    end

endmodule

// File: rtl/sent_crc_sched.sv
// Two-requester round-robin scheduler for the shared SENT CRC4 engine.
// Ports: clk, reset_n, req[1:0], data0/len0, data1/len1 in; gnt, busy, crc, crc_valid, crc_id out.
// Build option: SENT_CRC_LEGACY_EN skips the zero-nibble augmentation step.
import sent_pkg::*;

module sent_crc_sched #(
    parameter int MAX_NIBBLES = 6,
    parameter int LEN_W       = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [1:0]               req,
    input  logic [4*MAX_NIBBLES-1:0] data0,
    input  logic [LEN_W-1:0]         len0,
    input  logic [4*MAX_NIBBLES-1:0] data1,
    input  logic [LEN_W-1:0]         len1,
    output logic [1:0]               gnt,
    output logic                     busy,
    output logic [3:0]               crc,
    output logic                     crc_valid,
    output logic                     crc_id
);

    localparam int DW = 4 * MAX_NIBBLES;
    localparam int CW = $clog2(MAX_NIBBLES + 1);

`ifdef SENT_CRC_LEGACY_EN
    localparam state_t TAIL = DONE;
`else
    localparam state_t TAIL = AUG;
`endif

    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   sreg_q;
    logic [CW-1:0]   cnt_q;
    logic            owner_q;
    logic            ptr_q;
    logic [1:0]      mask_q;
    nibble_t         crc_hold_q;
    logic            id_hold_q;

    logic [1:0]      eff_req;
    logic            start;
    logic            pick;
    logic [DW-1:0]   pick_data;
    logic [LEN_W-1:0] pick_len;
    logic [CW-1:0]   clamp_len;

    logic            core_init;
    logic            core_en;
    nibble_t         core_din;
    nibble_t         core_dout;

    // Arbitration: the just-served requester is masked for one IDLE cycle
    always_comb begin
        eff_req   = req & ~mask_q;
        start     = (state_q == IDLE) && (|eff_req);
        pick      = eff_req[ptr_q] ? ptr_q : ~ptr_q;
        pick_data = pick ? data1 : data0;
        pick_len  = pick ? len1 : len0;
        if (int'(pick_len) > MAX_NIBBLES) begin
            clamp_len = CW'(MAX_NIBBLES);
        end else begin
            clamp_len = CW'(pick_len);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (clamp_len == '0) ? TAIL : CRC;
                end
            end
            CRC: begin
                if (cnt_q == CW'(1)) begin
                    state_d = TAIL;
                end
            end
            AUG:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_init = start;
        core_en   = (state_q == CRC) || (state_q == AUG);
        core_din  = (state_q == CRC) ? sreg_q[3:0] : 4'h0;
    end

    sent_crc4_core u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (core_init),
        .enable  (core_en),
        .din     (core_din),
        .dout    (core_dout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            ptr_q      <= 1'b0;
            mask_q     <= 2'b00;
            crc_hold_q <= 4'h0;
            id_hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= 2'b00;
            if (start) begin
                owner_q <= pick;
                sreg_q  <= pick_data;
                cnt_q   <= clamp_len;
            end
            if (state_q == CRC) begin
                sreg_q <= sreg_q >> 4;
                cnt_q  <= cnt_q - CW'(1);
            end
            if (state_q == DONE) begin
                crc_hold_q <= core_dout;
                id_hold_q  <= owner_q;
                ptr_q      <= ~owner_q;
                mask_q     <= owner_q ? 2'b10 : 2'b01;
            end
        end
    end

    // Result is live from the core in DONE, then held until the next DONE
    always_comb begin
        busy      = (state_q != IDLE);
        gnt       = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        crc_valid = (state_q == DONE);
        crc       = crc_valid ? core_dout : crc_hold_q;
        crc_id    = crc_valid ? owner_q : id_hold_q;
    end

endmodule

// File: tb/tb_sent_crc_sched.sv
// Self-checking bench for sent_crc_sched against a frame-level CRC/arbitration model.
// Honours SENT_CRC_LEGACY_EN when computing expected checksums and latencies.
module tb_sent_crc_sched;

    localparam int MAXN = 6;
`ifdef SENT_CRC_LEGACY_EN
    localparam int AUG_C = 0;
`else
    localparam int AUG_C = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    logic [23:0] data0;
    logic [2:0]  len0;
    logic [23:0] data1;
    logic [2:0]  len1;
    logic [1:0]  gnt;
    logic        busy;
    logic [3:0]  crc;
    logic        crc_valid;
    logic        crc_id;

    int   n_chk = 0;
    int   n_fail = 0;
    logic ptr_m;

    always #5 clk = ~clk;

    sent_crc_sched #(.MAX_NIBBLES(6), .LEN_W(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .data0     (data0),
        .len0      (len0),
        .data1     (data1),
        .len1      (len1),
        .gnt       (gnt),
        .busy      (busy),
        .crc       (crc),
        .crc_valid (crc_valid),
        .crc_id    (crc_id)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] tbl(input logic [3:0] i);
        logic [3:0] contrib [4];
        logic [3:0] r;
        contrib[0] = 4'hD;
        contrib[1] = 4'h7;
        contrib[2] = 4'hE;
        contrib[3] = 4'h1;
        r = 4'h0;
        for (int b = 0; b < 4; b++)
            if (i[b]) r = r ^ contrib[b];
        return r;
    endfunction

    function automatic int eff_len(input logic [2:0] l);
        return (int'(l) > MAXN) ? MAXN : int'(l);
    endfunction

    function automatic logic [3:0] ref_crc(input logic [23:0] d,
                                           input logic [2:0] l);
        logic [3:0] c;
        c = 4'h5;
        for (int k = 0; k < eff_len(l); k++)
            c = tbl(c) ^ d[4*k +: 4];
        if (AUG_C == 1) c = tbl(c);
        return c;
    endfunction

    function automatic logic [1:0] onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    task automatic wait_valid(input string tag, input logic [1:0] gexp,
                              input int gcyc, input bit scramble,
                              input bit drop, input logic id,
                              output int cyc);
        bit got;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1 && scramble) begin
                if (id) begin
                    data1 = 24'($urandom);
                    len1  = 3'($urandom);
                end else begin
                    data0 = 24'($urandom);
                    len0  = 3'($urandom);
                end
                if (drop) req[id] = 1'b0;
            end
            @(negedge clk);
            if (cyc == gcyc) begin
                check({tag, "_gnt"}, gnt, gexp);
                check({tag, "_busy"}, busy, 1);
            end
            if (crc_valid) got = 1'b1;
        end
        check({tag, "_seen"}, got, 1);
    endtask

    task automatic run_frame(input string tag, input logic id,
                             input logic [23:0] d, input logic [2:0] l,
                             input bit scramble, input bit drop,
                             output logic [3:0] res);
        int cyc;
        logic [3:0] exp;
        exp = ref_crc(d, l);
        @(posedge clk);
        #1;
        if (id) begin
            data1 = d;
            len1  = l;
        end else begin
            data0 = d;
            len0  = l;
        end
        req[id] = 1'b1;
        wait_valid(tag, onehot(id), 1, scramble, drop, id, cyc);
        res = crc;
        check({tag, "_lat"}, cyc, eff_len(l) + 1 + AUG_C);
        check({tag, "_crc"}, crc, exp);
        check({tag, "_id"}, crc_id, id);
        @(posedge clk);
        #1;
        req[id] = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, crc_valid, 0);
        check({tag, "_idle"}, {gnt, busy}, 0);
        check({tag, "_hold"}, {crc_id, crc}, {id, exp});
        ptr_m = ~id;
    endtask

    task automatic run_pair(input string tag, input logic [23:0] d0,
                            input logic [2:0] l0, input logic [23:0] d1,
                            input logic [2:0] l1);
        int cyc;
        logic fst;
        logic snd;
        logic [3:0] e0;
        logic [3:0] e1;
        fst = ptr_m;
        snd = ~ptr_m;
        e0 = ref_crc(d0, l0);
        e1 = ref_crc(d1, l1);
        @(posedge clk);
        #1;
        data0 = d0;
        len0  = l0;
        data1 = d1;
        len1  = l1;
        req   = 2'b11;
        wait_valid({tag, "_a"}, onehot(fst), 1, 1'b0, 1'b0, fst, cyc);
        check({tag, "_a_lat"}, cyc,
              eff_len(fst ? l1 : l0) + 1 + AUG_C);
        check({tag, "_a_id"}, crc_id, fst);
        check({tag, "_a_crc"}, crc, fst ? e1 : e0);
        wait_valid({tag, "_b"}, onehot(snd), 2, 1'b1, 1'b1, fst, cyc);
        check({tag, "_b_lat"}, cyc,
              eff_len(snd ? l1 : l0) + 2 + AUG_C);
        check({tag, "_b_id"}, crc_id, snd);
        check({tag, "_b_crc"}, crc, snd ? e1 : e0);
        @(posedge clk);
        #1;
        req = 2'b00;
        @(negedge clk);
        check({tag, "_idle"}, busy, 0);
        ptr_m = fst;
    endtask

    initial begin
        logic [3:0] res;
        reset_n = 1'b0;
        req     = 2'b00;
        data0   = '0;
        data1   = '0;
        len0    = '0;
        len1    = '0;
        ptr_m   = 1'b0;
        #2;
        check("rst_out", {gnt, busy, crc, crc_valid, crc_id}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_pair("both", 24'($urandom), 3'($urandom_range(1, 6)),
                 24'($urandom), 3'($urandom_range(1, 6)));

        run_frame("zero6", 1'b0, 24'h0, 3'd6, 1'b0, 1'b0, res);
        check("zero6_k", res, (AUG_C == 1) ? 4'h5 : 4'hF);

        run_frame("len0", 1'b1, 24'($urandom), 3'd0, 1'b0, 1'b0, res);
        check("len0_k", res, (AUG_C == 1) ? 4'h3 : 4'h5);

        run_frame("clamp", 1'b0, 24'($urandom), 3'd7, 1'b0, 1'b0, res);
        run_frame("drop", 1'b0, 24'($urandom), 3'd5, 1'b1, 1'b1, res);

        @(posedge clk);
        #1;
        data0 = 24'($urandom);
        len0  = 3'd6;
        req   = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid", {gnt, busy, crc, crc_valid, crc_id}, 0);
        req = 2'b00;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ptr_m = 1'b0;
        run_frame("after_rst", 1'b1, 24'($urandom), 3'd4, 1'b0, 1'b0, res);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                run_pair("rnd_pair", 24'($urandom), 3'($urandom),
                         24'($urandom), 3'($urandom));
            end else begin
                run_frame("rnd", 1'($urandom), 24'($urandom),
                          3'($urandom), 1'($urandom), 1'($urandom), res);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
